// File: rtl/ipv4_tx_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ipv4_tx_frame_scheduler                                        |
// | Purpose  : frame-atomic priority/round-robin arbiter for the IPv4 TX path |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module ipv4_tx_frame_scheduler #(
  parameter int NUM_PORTS      = 4,
  parameter int MAX_BURST      = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PORTS-1:0]         i_req,
  input  logic [NUM_PORTS-1:0]         i_prio_mask,
  input  logic                         i_tx_ready,
  input  logic                         i_frame_done,
  output logic [NUM_PORTS-1:0]         o_grant,
  output logic                         o_grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0] o_grant_id,
  output logic                         o_abort,
  output logic [15:0]                  o_timeout_count
);

  localparam int c_IW = $clog2(NUM_PORTS);
  localparam int c_BW = $clog2(MAX_BURST + 1);
  localparam int c_GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int c_WW = $clog2(TIMEOUT_CYCLES);

  localparam logic [c_IW:0]   c_NPORTS    = (c_IW + 1)'(NUM_PORTS);
  localparam logic [c_BW-1:0] c_BURST_CAP = c_BW'(MAX_BURST);
  localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [c_WW-1:0] c_WD_LAST   = c_WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t                r_state,         w_state_nxt;
  logic [NUM_PORTS-1:0]  r_grant,         w_grant_nxt;
  logic                  r_grant_valid,   w_grant_valid_nxt;
  logic [c_IW-1:0]       r_grant_id,      w_grant_id_nxt;
  logic                  r_abort,         w_abort_nxt;
  logic [15:0]           r_timeout_count, w_timeout_count_nxt;
  logic [c_IW-1:0]       r_rr,            w_rr_nxt;
  logic [c_BW-1:0]       r_burst,         w_burst_nxt;
  logic [c_WW-1:0]       r_wd,            w_wd_nxt;
  logic [c_GW-1:0]       r_gap,           w_gap_nxt;

  logic [NUM_PORTS-1:0]   w_prio_req;
  logic [NUM_PORTS-1:0]   w_np_req;
  logic                   w_use_np;
  logic [NUM_PORTS-1:0]   w_cand;
  logic [2*NUM_PORTS-1:0] w_rot2;
  logic [c_IW-1:0]        w_off;
  logic [c_IW:0]          w_sum;
  logic [c_IW-1:0]        w_pick_id;
  logic [c_IW:0]          w_inc;
  logic [c_IW-1:0]        w_rr_adv;
  logic                   w_wd_hit;

  // Candidate class, then first requester at or after r_rr via a doubled-and-rotated mask.
  always_comb begin
    w_prio_req = i_req & i_prio_mask;
    w_np_req   = i_req & ~i_prio_mask;
    w_use_np   = ~|w_prio_req || ((r_burst >= c_BURST_CAP) && |w_np_req);
    w_cand     = w_use_np ? w_np_req : w_prio_req;
    w_rot2     = {w_cand, w_cand} >> r_rr;
    w_off      = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_rot2[k]) w_off = c_IW'(k);
    end
    w_sum     = {1'b0, r_rr} + {1'b0, w_off};
    w_pick_id = (w_sum >= c_NPORTS) ? c_IW'(w_sum - c_NPORTS) : c_IW'(w_sum);
    w_inc     = {1'b0, r_grant_id} + (c_IW + 1)'(1);
    w_rr_adv  = (w_inc >= c_NPORTS) ? '0 : c_IW'(w_inc);
    w_wd_hit  = (r_wd == c_WD_LAST);
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_grant_nxt         = r_grant;
    w_grant_valid_nxt   = r_grant_valid;
    w_grant_id_nxt      = r_grant_id;
    w_abort_nxt         = 1'b0;
    w_timeout_count_nxt = r_timeout_count;
    w_rr_nxt            = r_rr;
    w_burst_nxt         = r_burst;
    w_wd_nxt            = r_wd;
    w_gap_nxt           = r_gap;
    case (r_state)
      S_IDLE: begin
        if (~|w_np_req) w_burst_nxt = '0;
        if (i_tx_ready && |i_req) begin
          w_state_nxt       = S_ACTIVE;
          w_grant_nxt       = NUM_PORTS'(1) << w_pick_id;
          w_grant_valid_nxt = 1'b1;
          w_grant_id_nxt    = w_pick_id;
          w_wd_nxt          = '0;
          if (!w_use_np && |w_np_req) w_burst_nxt = r_burst + c_BW'(1);
          else                        w_burst_nxt = '0;
        end
      end
      S_ACTIVE: begin
        w_wd_nxt = r_wd + c_WW'(1);
        // A done coinciding with watchdog expiry wins; abort is registered, so it
        // shows up together with the grant drop.
        if (i_frame_done || w_wd_hit) begin
          w_grant_nxt       = '0;
          w_grant_valid_nxt = 1'b0;
          w_grant_id_nxt    = '0;
          w_rr_nxt          = w_rr_adv;
          w_wd_nxt          = '0;
          w_gap_nxt         = '0;
          w_state_nxt       = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          if (!i_frame_done) begin
            w_abort_nxt = 1'b1;
            if (r_timeout_count != 16'hFFFF) w_timeout_count_nxt = r_timeout_count + 16'd1;
          end
        end
      end
      S_GAP: begin
        w_gap_nxt = r_gap + c_GW'(1);
        if (r_gap == c_GAP_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_grant         <= '0;
      r_grant_valid   <= 1'b0;
      r_grant_id      <= '0;
      r_abort         <= 1'b0;
      r_timeout_count <= '0;
      r_rr            <= '0;
      r_burst         <= '0;
      r_wd            <= '0;
      r_gap           <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_grant         <= w_grant_nxt;
      r_grant_valid   <= w_grant_valid_nxt;
      r_grant_id      <= w_grant_id_nxt;
      r_abort         <= w_abort_nxt;
      r_timeout_count <= w_timeout_count_nxt;
      r_rr            <= w_rr_nxt;
      r_burst         <= w_burst_nxt;
      r_wd            <= w_wd_nxt;
      r_gap           <= w_gap_nxt;
    end
  end

  assign o_grant         = r_grant;
  assign o_grant_valid   = r_grant_valid;
  assign o_grant_id      = r_grant_id;
  assign o_abort         = r_abort;
  assign o_timeout_count = r_timeout_count;

endmodule
`default_nettype wire
